// File: rtl/alimentador_pkg.sv
// Package for the ring feeder alimentador_anillo.
// Holds the lane count, the row/column index width, the FSM state
// encoding and the default coefficient width shared by the feeder
// and its column selector.
package alimentador_pkg;

    localparam int N_LANES   = 4;
    localparam int IDX_W     = 2;
    localparam int W_DEFAULT = 16;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FIN    = 2'd2
    } state_t;

endpackage

// File: rtl/alimentador_selector_diagonal.sv
// selector_diagonal: column select for one lane of the skewed stream.
// Lane i at beat k reads column (i + k) mod 4.
// Ports:
//   lane  in  IDX_W  lane index i (constant per instance)
//   beat  in  IDX_W  beat counter k
//   col   out IDX_W  selected column (i + k) mod 4
module selector_diagonal
    import alimentador_pkg::*;
(
    input  idx_t lane,
    input  idx_t beat,
    output idx_t col
);

    // Both operands are IDX_W bits wide, so the sum wraps modulo 4 for free.
    assign col = lane + beat;

endmodule

// File: rtl/alimentador_anillo.sv
// alimentador_anillo: upstream feeder for the 4-lane systolic ring.
// Stores a 4x4 matrix of W-bit coefficients written one word at a time,
// and on start streams it into the ring as four diagonal beats:
// lane i at beat k carries M[i][(i+k) mod 4].
// Ports:
//   clk           in   single clock, rising edge
//   reset         in   asynchronous active-low reset
//   wr_en         in   write strobe for the matrix store (IDLE only)
//   wr_fila       in   row index of the write
//   wr_col        in   column index of the write
//   wr_dato       in   coefficient written to M[wr_fila][wr_col]
//   start         in   request one 4-beat stream (level, sampled each cycle)
//   a1..a4        out  registered lane outputs, zero outside a beat
//   a_valid       out  high while a1..a4 carry a beat
//   busy          out  high in STREAM and FIN
//   done          out  one-cycle pulse after the last beat
//   err           out  one-cycle pulse when start or wr_en is rejected
module alimentador_anillo
    import alimentador_pkg::*;
#(
    parameter int W = W_DEFAULT
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_fila,
    input  logic [IDX_W-1:0] wr_col,
    input  logic [W-1:0]     wr_dato,
    input  logic             start,
    output logic [W-1:0]     a1,
    output logic [W-1:0]     a2,
    output logic [W-1:0]     a3,
    output logic [W-1:0]     a4,
    output logic             a_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t state_q, state_d;
    idx_t   k_q, k_d;

    logic [W-1:0] m_q    [N_LANES][N_LANES];
    logic [W-1:0] m_d    [N_LANES][N_LANES];
    logic [W-1:0] lane_q [N_LANES];
    logic [W-1:0] lane_d [N_LANES];
    idx_t         col    [N_LANES];

    logic in_busy;
    logic wr_ok;
    logic err_d;
    logic a_valid_q, busy_q, done_q, err_q;

    assign in_busy = (state_q != IDLE);
    assign wr_ok   = wr_en && !in_busy;
    // A single pulse covers a rejected start, a rejected write, or both.
    assign err_d   = in_busy && (wr_en || start);

    // ------------------------------------------------------------------
    // FSM next state and beat counter
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case leaves it unassigned (no latch).
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    k_d     = '0;
                end
            end
            STREAM: begin
                if (k_q == idx_t'(N_LANES - 1)) begin
                    state_d = FIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + idx_t'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Matrix store next value. The lane mux reads m_d rather than m_q so
    // that a write landing on the same edge as start is already visible
    // in beat 0.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: combinational blocks use blocking '='; the later write to
        // one element overrides the copy made just above it.
        m_d = m_q;
        if (wr_ok) begin
            m_d[wr_fila][wr_col] = wr_dato;
        end
    end

    // One diagonal column selector per lane, driven by the next beat index
    // because the lane outputs are registered.
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_sel
        selector_diagonal u_sel (
            .lane (idx_t'(gi)),
            .beat (k_d),
            .col  (col[gi])
        );
    end

    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            lane_d[i] = (state_d == STREAM) ? m_d[i][col[i]] : '0;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples values from before the edge.
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // ------------------------------------------------------------------
    // Matrix store and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the coefficient store is cleared on reset on purpose; a
            // stream started straight after reset must read all zeros.
            for (int r = 0; r < N_LANES; r++) begin
                for (int c = 0; c < N_LANES; c++) begin
                    m_q[r][c] <= '0;
                end
            end
            for (int i = 0; i < N_LANES; i++) begin
                lane_q[i] <= '0;
            end
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            m_q       <= m_d;
            lane_q    <= lane_d;
            a_valid_q <= (state_d == STREAM);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == FIN);
            err_q     <= err_d;
        end
    end

    assign a1      = lane_q[0];
    assign a2      = lane_q[1];
    assign a3      = lane_q[2];
    assign a4      = lane_q[3];
    assign a_valid = a_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_alimentador_anillo.sv
// Scoreboard bench for alimentador_anillo. Stimulus pushes expected beats,
// done pulses and err pulses (tagged with the cycle they must appear in)
// into queues; a monitor on the falling edge pops and compares them.
module tb_alimentador_anillo;
    import alimentador_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [1:0]   wr_fila;
    logic [1:0]   wr_col;
    logic [W-1:0] wr_dato;
    logic         start;
    logic [W-1:0] a1, a2, a3, a4;
    logic         a_valid, busy, done, err;

    alimentador_anillo #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_fila (wr_fila),
        .wr_col  (wr_col),
        .wr_dato (wr_dato),
        .start   (start),
        .a1      (a1),
        .a2      (a2),
        .a3      (a3),
        .a4      (a4),
        .a_valid (a_valid),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } beat_t;

    beat_t q_beat[$];
    int    q_done[$];
    int    q_err[$];

    int checks      = 0;
    int failures    = 0;
    int cyc         = 0;
    int busy_cycles = 0;

    // Hand-computed beats for M[r][c] = 4r+c+1, packed {a1,a2,a3,a4}.
    localparam logic [63:0] B0 = {16'd1, 16'd6, 16'd11, 16'd16};
    localparam logic [63:0] B1 = {16'd2, 16'd7, 16'd12, 16'd13};
    localparam logic [63:0] B2 = {16'd3, 16'd8, 16'd9,  16'd14};
    localparam logic [63:0] B3 = {16'd4, 16'd5, 16'd10, 16'd15};
    // Beat 0 after M[2][2] is overwritten with 16'h00AA.
    localparam logic [63:0] B0_AA = {16'd1, 16'd6, 16'h00AA, 16'd16};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input int t, input logic [63:0] b0, input logic [63:0] b1,
                               input logic [63:0] b2, input logic [63:0] b3);
        q_beat.push_back('{cyc: t,     data: b0});
        q_beat.push_back('{cyc: t + 1, data: b1});
        q_beat.push_back('{cyc: t + 2, data: b2});
        q_beat.push_back('{cyc: t + 3, data: b3});
        q_done.push_back(t + 4);
    endtask

    task automatic write_word(input int r, input int c, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_fila = r[1:0];
        wr_col  = c[1:0];
        wr_dato = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Cycle counter: value after edge e is e.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: compare everything the DUT presents against the queues.
    initial begin
        beat_t e;
        int    ec;
        forever begin
            @(negedge clk);
            if (a_valid) begin
                if (q_beat.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_extra: got beat %h at cycle %0d, expected none",
                             {a1, a2, a3, a4}, cyc);
                end else begin
                    e = q_beat.pop_front();
                    check("beat_cycle", 64'(cyc), 64'(e.cyc));
                    check("beat_data", {a1, a2, a3, a4}, e.data);
                end
            end else begin
                check("lanes_zero_when_invalid", {a1, a2, a3, a4}, 64'd0);
            end
            if (busy) busy_cycles++;
            if (done) begin
                if (q_done.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_extra: got done at cycle %0d, expected none", cyc);
                end else begin
                    ec = q_done.pop_front();
                    check("done_cycle", 64'(cyc), 64'(ec));
                end
            end
            if (err) begin
                if (q_err.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL err_extra: got err at cycle %0d, expected none", cyc);
                end else begin
                    ec = q_err.pop_front();
                    check("err_cycle", 64'(cyc), 64'(ec));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int c0;
        int b0;

        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_fila = '0;
        wr_col  = '0;
        wr_dato = '0;
        start   = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset_lanes",   {a1, a2, a3, a4}, 64'd0);
        check("reset_a_valid", 64'(a_valid), 64'd0);
        check("reset_busy",    64'(busy), 64'd0);
        check("reset_done",    64'(done), 64'd0);
        check("reset_err",     64'(err), 64'd0);
        reset = 1'b1;
        tick();

        // Load M[r][c] = 4r+c+1
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                write_word(r, c, W'(4 * r + c + 1));
            end
        end

        // Diagonal stream
        b0 = busy_cycles;
        t = cyc + 1;
        push_stream(t, B0, B1, B2, B3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("busy_cycles_single", 64'(busy_cycles - b0), 64'd5);

        // Reject during busy: write and start together mid-stream
        t = cyc + 1;
        push_stream(t, B0, B1, B2, B3);
        start = 1'b1;
        tick();
        wr_en   = 1'b1;
        wr_fila = 2'd0;
        wr_col  = 2'd0;
        wr_dato = 16'hFFFF;
        q_err.push_back(cyc + 1);
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        repeat (8) tick();
        // Next stream must still see M[0][0] = 1
        t = cyc + 1;
        push_stream(t, B0, B1, B2, B3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();

        // Write and start in the same IDLE cycle
        t = cyc + 1;
        push_stream(t, B0_AA, B1, B2, B3);
        wr_en   = 1'b1;
        wr_fila = 2'd2;
        wr_col  = 2'd2;
        wr_dato = 16'h00AA;
        start   = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        repeat (8) tick();

        // Back-to-back with start held high
        c0 = cyc;
        b0 = busy_cycles;
        push_stream(c0 + 1, B0_AA, B1, B2, B3);
        push_stream(c0 + 7, B0_AA, B1, B2, B3);
        for (int i = 2; i <= 6; i++) q_err.push_back(c0 + i);
        start = 1'b1;
        repeat (7) tick();
        start = 1'b0;
        repeat (8) tick();
        check("busy_cycles_back_to_back", 64'(busy_cycles - b0), 64'd10);

        // Reset during beat 1
        t = cyc + 1;
        q_beat.push_back('{cyc: t,     data: B0_AA});
        q_beat.push_back('{cyc: t + 1, data: B1});
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midreset_lanes",   {a1, a2, a3, a4}, 64'd0);
        check("midreset_a_valid", 64'(a_valid), 64'd0);
        check("midreset_busy",    64'(busy), 64'd0);
        check("midreset_done",    64'(done), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        // Store was cleared: every beat is zero
        t = cyc + 1;
        push_stream(t, 64'd0, 64'd0, 64'd0, 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();

        check("beats_outstanding", 64'(q_beat.size()), 64'd0);
        check("done_outstanding",  64'(q_done.size()), 64'd0);
        check("err_outstanding",   64'(q_err.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
